id_stage: RTL and testbench
===========================

// Module: id_stage
// PURPOSE
//  RV32I decode stage. Sits between the IF/ID register and EX.
//  Decodes the IF/ID instruction and reads two operands from an owned register file.
//  Writes from WB update that register file.
//  Generates the sign-extended immediate, detects load-use hazards and drives
//  the ID/EX pipeline register. Latency is one cycle from IF/ID to ID/EX.
// PARAMETERS
//  XLEN       32  data/address width; only 32 is supported
//  NUM_REGS   32  architectural registers; x0 is hardwired to zero
//  WB_BYPASS  1   1 = WB write visible to same-cycle decode read
// PORTS
//  clk             in   1     clock, rising edge
//  rst_n           in   1     reset, asynchronous assert, active-low
//  if_id_i         in   IF_ID_t  {pc, instr, valid} from the IF/ID register
//  flush_id        in   1     branch/jump resolved in EX; kill the instruction in decode
//  wb_we           in   1     register-file write enable from WB
//  wb_rd           in   5     write address
//  wb_data         in   32    write data
//  stall_o         out  1     load-use stall; drives stall_if of the fetch stage
//  id_ex_o         out  ID_EX_t  ID/EX pipeline register
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - id_ex_o is cleared to all zeros, including valid=0 and all control bits.
//   - All registers x1..x31 are cleared to 0.
//   - stall_o=0.
//  Register file:
//   - Writes occur at posedge when wb_we=1 and wb_rd!=0; writes to x0 are ignored.
//   - Reads are combinational. Reads of x0 return 0.
//   - If WB_BYPASS=1 and wb_we=1, wb_rd==rs and rs!=0, the read returns wb_data.
//  Decode (when if_id_i.valid=1):
//   - Opcode classes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
//   - Immediates use I/S/B/U/J formats. All are sign-extended to 32 bits;
//     B and J immediates have bit0=0.
//   - FENCE, ECALL and EBREAK decode as NOPs: valid=1, no write enables set.
//   - Any other opcode sets illegal=1, clears reg_write/mem_read/mem_write/branch/jump,
//     and keeps valid=1.
//   - Illegal funct3/funct7 combinations in OP/OP-IMM/LOAD/STORE/BRANCH also set illegal=1.
//   - rd=0 forces reg_write=0.
//   - use_rs1 and use_rs2 are derived per class. LUI, AUIPC and JAL use neither
//     source; I-type instructions use only rs1.
//  Load-use hazard:
//   - stall_o = if_id_i.valid & id_ex_o.valid & id_ex_o.mem_read & id_ex_o.rd!=0 &
//     ((use_rs1 & rs1==id_ex_o.rd) | (use_rs2 & rs2==id_ex_o.rd)) & !flush_id.
//   - stall_o is combinational; the decoded instruction is held by IF via stall_if.
//  ID/EX register update priority at posedge:
//   1. flush_id: bubble. valid=0, all control bits 0, pc retained for debug.
//   2. stall_o: bubble, same encoding as flush.
//   3. if_id_i.valid=0: bubble.
//   4. otherwise: latch the decoded fields.
//  Back-to-back behaviour:
//   - A load followed by a dependent instruction costs exactly one bubble.
//   - On the next cycle id_ex_o holds the bubble, so stall_o deasserts.
//   - flush_id and stall_o in the same cycle: flush wins and stall_o=0.
//   - A WB write and a decode read of the same register in the same cycle
//     return the new value (WB_BYPASS=1).
//  Reset mid-operation clears the ID/EX register immediately, without waiting for a clock edge.
// STRUCTURE
//  Shared package riscv_pkg:
//   - IF_ID_t.
//   - ID_EX_t = {pc, rs1_data, rs2_data, imm, rs1, rs2, rd, alu_op, alu_src_imm,
//     alu_src_pc, reg_write, mem_read, mem_write, mem_size[1:0], mem_unsigned,
//     branch, jump, jalr, illegal, valid}.
//   - alu_op_e enum.
//   - Opcode and funct3 localparams.
//   - NOP constant 32'h00000013.
//  Sub-module reg_file: 2 read ports, 1 write port, async reset, optional WB bypass.
//  Decode, immediate generation and hazard logic are always_comb inside id_stage.
// TESTING
//  1. Reset then idle.
//     rst_n=0 mid-cycle -> id_ex_o.valid=0 with no clock edge; rf x5 reads 0; stall_o=0.
//  2. ADDI x1,x0,-5 (0xFFB00093), valid.
//     -> next cycle: imm=0xFFFFFFFB, rd=1, alu_src_imm=1, reg_write=1, valid=1.
//  3. Load-use.
//     LW x2,0(x1) then ADD x3,x2,x2 -> stall_o=1 for one cycle; one bubble in ID/EX;
//     the ADD is then latched with rs1=rs2=2.
//  4. WB bypass.
//     wb_we=1, wb_rd=7, wb_data=0xDEADBEEF in the same cycle as decoding ADD x8,x7,x0
//     -> rs1_data=0xDEADBEEF.
//     Writing wb_rd=0 and then reading x0 -> 0.
//  5. Flush over stall.
//     Load-use condition plus flush_id=1 -> stall_o=0; id_ex_o is a bubble with valid=0.
//  6. Illegal opcode 0x0000007F -> illegal=1, valid=1, reg_write=mem_write=0.
//     BEQ with imm -8 -> imm=0xFFFFFFF8, branch=1.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I types and encodings for the decode stage and its neighbours.
package riscv_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_JALR  = 3'b000;
  localparam logic [2:0] F3_FENCE = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [31:0] NOP          = 32'h00000013;
  localparam logic [31:0] INSTR_ECALL  = 32'h00000073;
  localparam logic [31:0] INSTR_EBREAK = 32'h00100073;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
  } alu_op_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } IF_ID_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    alu_op_e     alu_op;
    logic        alu_src_imm;
    logic        alu_src_pc;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic        branch;
    logic        jump;
    logic        jalr;
    logic        illegal;
    logic        valid;
  } ID_EX_t;

  // alt selects SUB/SRA over ADD/SRL (instr bit 30)
  function automatic alu_op_e alu_op_from_f3(logic [2:0] f3, logic alt);
    case (f3)
      F3_ADD_SUB: return alt ? ALU_SUB : ALU_ADD;
      F3_SLL:     return ALU_SLL;
      F3_SLT:     return ALU_SLT;
      F3_SLTU:    return ALU_SLTU;
      F3_XOR:     return ALU_XOR;
      F3_SRL_SRA: return alt ? ALU_SRA : ALU_SRL;
      F3_OR:      return ALU_OR;
      F3_AND:     return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/reg_file.sv
// Integer register file: two combinational read ports, one write port,
// x0 hardwired to zero, optional same-cycle write-to-read bypass.
module reg_file #(
  parameter int XLEN      = 32,
  parameter int NUM_REGS  = 32,
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            we,
  input  logic [4:0]      wr_addr,
  input  logic [XLEN-1:0] wr_data
);

  logic [XLEN-1:0] regs [NUM_REGS];

  // Write port; x0 is never written so it keeps its reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we && wr_addr != 5'd0) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Read port 1 with optional bypass of the in-flight WB write.
  always_comb begin
    rs1_data = '0;
    if (rs1_addr != 5'd0) begin
      if (WB_BYPASS && we && wr_addr == rs1_addr) rs1_data = wr_data;
      else                                        rs1_data = regs[rs1_addr];
    end
  end

  // Read port 2, same rules as port 1.
  always_comb begin
    rs2_data = '0;
    if (rs2_addr != 5'd0) begin
      if (WB_BYPASS && we && wr_addr == rs2_addr) rs2_data = wr_data;
      else                                        rs2_data = regs[rs2_addr];
    end
  end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: decode, immediate generation, operand read,
// load-use hazard detection and the ID/EX pipeline register.
module id_stage
  import riscv_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int NUM_REGS  = 32,
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  IF_ID_t          if_id_i,
  input  logic            flush_id,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            stall_o,
  output ID_EX_t          id_ex_o
);

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_data, rs2_data;
  logic        use_rs1, use_rs2;
  logic        nop_alias;
  ID_EX_t      dec;
  ID_EX_t      bubble;

  // FENCE, ECALL and EBREAK have no effect here, so they are decoded as the canonical NOP.
  assign nop_alias = (if_id_i.instr[6:0] == OPC_MISC_MEM && if_id_i.instr[14:12] == F3_FENCE)
                   || if_id_i.instr == INSTR_ECALL || if_id_i.instr == INSTR_EBREAK;
  assign instr  = nop_alias ? NOP : if_id_i.instr;
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  reg_file #(
    .XLEN      (XLEN),
    .NUM_REGS  (NUM_REGS),
    .WB_BYPASS (WB_BYPASS)
  ) u_reg_file (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs1_addr (rs1),
    .rs2_addr (rs2),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .we       (wb_we),
    .wr_addr  (wb_rd),
    .wr_data  (wb_data)
  );

  // Instruction decode into ID/EX fields plus source-usage flags.
  always_comb begin
    dec          = '0;
    use_rs1      = 1'b0;
    use_rs2      = 1'b0;
    dec.pc       = if_id_i.pc;
    dec.rs1      = rs1;
    dec.rs2      = rs2;
    dec.rd       = rd;
    dec.rs1_data = rs1_data;
    dec.rs2_data = rs2_data;
    dec.alu_op   = ALU_ADD;
    dec.valid    = 1'b1;
    case (opcode)
      OPC_LUI: begin
        dec.imm = imm_u; dec.alu_op = ALU_PASS_B; dec.alu_src_imm = 1'b1; dec.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        dec.imm = imm_u; dec.alu_src_imm = 1'b1; dec.alu_src_pc = 1'b1; dec.reg_write = 1'b1;
      end
      OPC_JAL: begin
        dec.imm = imm_j; dec.alu_src_imm = 1'b1; dec.alu_src_pc = 1'b1;
        dec.jump = 1'b1; dec.reg_write = 1'b1;
      end
      OPC_JALR: begin
        dec.imm = imm_i; dec.alu_src_imm = 1'b1; dec.jump = 1'b1; dec.jalr = 1'b1;
        dec.reg_write = 1'b1; use_rs1 = 1'b1;
        dec.illegal = (funct3 != F3_JALR);
      end
      OPC_BRANCH: begin
        dec.imm = imm_b; dec.branch = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
        case (funct3)
          F3_BEQ, F3_BNE:   dec.alu_op = ALU_SUB;
          F3_BLT, F3_BGE:   dec.alu_op = ALU_SLT;
          F3_BLTU, F3_BGEU: dec.alu_op = ALU_SLTU;
          default:          dec.illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec.imm = imm_i; dec.alu_src_imm = 1'b1; dec.mem_read = 1'b1; dec.reg_write = 1'b1;
        dec.mem_size = funct3[1:0]; dec.mem_unsigned = funct3[2]; use_rs1 = 1'b1;
        dec.illegal = !(funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
      end
      OPC_STORE: begin
        dec.imm = imm_s; dec.alu_src_imm = 1'b1; dec.mem_write = 1'b1;
        dec.mem_size = funct3[1:0]; use_rs1 = 1'b1; use_rs2 = 1'b1;
        dec.illegal = !(funct3 inside {F3_LB, F3_LH, F3_LW});
      end
      OPC_OP_IMM: begin
        dec.imm = imm_i; dec.alu_src_imm = 1'b1; dec.reg_write = 1'b1; use_rs1 = 1'b1;
        dec.alu_op = alu_op_from_f3(funct3, funct3 == F3_SRL_SRA && funct7[5]);
        if (funct3 == F3_SLL)     dec.illegal = (funct7 != F7_BASE);
        if (funct3 == F3_SRL_SRA) dec.illegal = (funct7 != F7_BASE && funct7 != F7_ALT);
      end
      OPC_OP: begin
        dec.reg_write = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
        dec.alu_op = alu_op_from_f3(funct3, funct7[5]);
        dec.illegal = !(funct7 == F7_BASE ||
                        (funct7 == F7_ALT && (funct3 == F3_ADD_SUB || funct3 == F3_SRL_SRA)));
      end
      default: dec.illegal = 1'b1;
    endcase
    // An illegal instruction must not touch architectural state or create stalls.
    if (dec.illegal) begin
      dec.reg_write = 1'b0;
      dec.mem_read  = 1'b0;
      dec.mem_write = 1'b0;
      dec.branch    = 1'b0;
      dec.jump      = 1'b0;
      dec.jalr      = 1'b0;
      use_rs1       = 1'b0;
      use_rs2       = 1'b0;
    end
    if (rd == 5'd0) dec.reg_write = 1'b0;
  end

  // Load-use hazard: a load in EX whose result is needed by the decoding instruction.
  always_comb begin
    stall_o = if_id_i.valid && id_ex_o.valid && id_ex_o.mem_read && id_ex_o.rd != 5'd0 &&
              ((use_rs1 && rs1 == id_ex_o.rd) || (use_rs2 && rs2 == id_ex_o.rd)) &&
              !flush_id;
  end

  // Bubble encoding: everything zero except the pc, kept for debug visibility.
  always_comb begin
    bubble    = '0;
    bubble.pc = id_ex_o.pc;
  end

  // ID/EX register: flush, stall and empty slots all insert a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_ex_o <= '0;
    end else if (flush_id || stall_o || !if_id_i.valid) begin
      id_ex_o <= bubble;
    end else begin
      id_ex_o <= dec;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Directed self-checking bench for the RV32I decode stage.
module tb_id_stage;
  import riscv_pkg::*;

  logic        clk;
  logic        rst_n;
  IF_ID_t      if_id;
  logic        flush_id;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        stall;
  ID_EX_t      id_ex;

  int total = 0;
  int bad   = 0;

  id_stage #(.XLEN(32), .NUM_REGS(32), .WB_BYPASS(1'b1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_id_i  (if_id),
    .flush_id (flush_id),
    .wb_we    (wb_we),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .stall_o  (stall),
    .id_ex_o  (id_ex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
    if_id.instr = instr;
    if_id.pc    = pc;
    if_id.valid = 1'b1;
  endtask

  localparam logic [31:0] I_ADDI   = 32'hFFB00093; // addi x1,x0,-5
  localparam logic [31:0] I_ADD955 = 32'h005284B3; // add x9,x5,x5
  localparam logic [31:0] I_LW     = 32'h0000A103; // lw x2,0(x1)
  localparam logic [31:0] I_LUI    = 32'h000102B7; // lui x5,0x10 (bits 19:15 == 2)
  localparam logic [31:0] I_ADD322 = 32'h002101B3; // add x3,x2,x2
  localparam logic [31:0] I_ADD870 = 32'h00038433; // add x8,x7,x0
  localparam logic [31:0] I_ADD100 = 32'h00000533; // add x10,x0,x0
  localparam logic [31:0] I_ILL1   = 32'h0000007F;
  localparam logic [31:0] I_ILL2   = 32'h00000FFF; // bad opcode, rd=31
  localparam logic [31:0] I_ILLOP  = 32'h400010B3; // sll with funct7=0100000
  localparam logic [31:0] I_BEQ    = 32'hFE208CE3; // beq x1,x2,-8
  localparam logic [31:0] I_ECALL  = 32'h00000073;
  localparam logic [31:0] I_SW     = 32'hFE20AE23; // sw x2,-4(x1)

  initial begin
    rst_n    = 1'b0;
    if_id    = '0;
    flush_id = 1'b0;
    wb_we    = 1'b0;
    wb_rd    = 5'd0;
    wb_data  = 32'd0;

    // reset state
    #12;
    check_val("rst_valid", {31'd0, id_ex.valid}, 32'd0);
    check_val("rst_all_zero", {31'd0, id_ex == '0}, 32'd1);
    check_val("rst_stall", {31'd0, stall}, 32'd0);
    rst_n = 1'b1;

    // ADDI, with a WB write to x5 in the same cycle
    drive(I_ADDI, 32'h100);
    wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'h00001234;
    tick();
    wb_we = 1'b0;
    check_val("addi_imm", id_ex.imm, 32'hFFFFFFFB);
    check_val("addi_rd", {27'd0, id_ex.rd}, 32'd1);
    check_val("addi_src_imm", {31'd0, id_ex.alu_src_imm}, 32'd1);
    check_val("addi_reg_write", {31'd0, id_ex.reg_write}, 32'd1);
    check_val("addi_valid", {31'd0, id_ex.valid}, 32'd1);
    check_val("addi_pc", id_ex.pc, 32'h100);

    // asynchronous reset between clock edges
    #2 rst_n = 1'b0;
    #1;
    check_val("async_rst_valid", {31'd0, id_ex.valid}, 32'd0);
    check_val("async_rst_zero", {31'd0, id_ex == '0}, 32'd1);
    check_val("async_rst_stall", {31'd0, stall}, 32'd0);
    #1 rst_n = 1'b1;
    drive(I_ADD955, 32'h104);
    tick();
    check_val("x5_after_rst_a", id_ex.rs1_data, 32'd0);
    check_val("x5_after_rst_b", id_ex.rs2_data, 32'd0);

    // load followed by LUI whose immediate aliases rs1=2: no stall
    drive(I_LW, 32'h108);
    tick();
    check_val("lw_mem_read", {31'd0, id_ex.mem_read}, 32'd1);
    check_val("lw_mem_size", {30'd0, id_ex.mem_size}, 32'd2);
    check_val("lw_reg_write", {31'd0, id_ex.reg_write}, 32'd1);
    drive(I_LUI, 32'h10C);
    #1;
    check_val("lui_no_stall", {31'd0, stall}, 32'd0);
    tick();
    check_val("lui_imm", id_ex.imm, 32'h00010000);
    check_val("lui_rd", {27'd0, id_ex.rd}, 32'd5);

    // load-use: one bubble then the dependent ADD
    drive(I_LW, 32'h110);
    tick();
    drive(I_ADD322, 32'h114);
    #1;
    check_val("lu_stall", {31'd0, stall}, 32'd1);
    tick();
    check_val("lu_bubble_valid", {31'd0, id_ex.valid}, 32'd0);
    check_val("lu_bubble_mem_read", {31'd0, id_ex.mem_read}, 32'd0);
    check_val("lu_stall_drop", {31'd0, stall}, 32'd0);
    tick();
    check_val("lu_add_valid", {31'd0, id_ex.valid}, 32'd1);
    check_val("lu_add_rs1", {27'd0, id_ex.rs1}, 32'd2);
    check_val("lu_add_rs2", {27'd0, id_ex.rs2}, 32'd2);
    check_val("lu_add_rd", {27'd0, id_ex.rd}, 32'd3);
    check_val("lu_add_op", {28'd0, id_ex.alu_op}, {28'd0, ALU_ADD});

    // WB bypass, then x0 write ignored
    drive(I_ADD870, 32'h118);
    wb_we = 1'b1; wb_rd = 5'd7; wb_data = 32'hDEADBEEF;
    tick();
    check_val("bypass_rs1", id_ex.rs1_data, 32'hDEADBEEF);
    check_val("bypass_rs2", id_ex.rs2_data, 32'd0);
    drive(I_ADD100, 32'h11C);
    wb_rd = 5'd0; wb_data = 32'hFFFFFFFF;
    tick();
    wb_we = 1'b0;
    check_val("x0_same_cycle", id_ex.rs1_data, 32'd0);
    tick();
    check_val("x0_after_write", id_ex.rs1_data, 32'd0);
    drive(I_ADD870, 32'h120);
    tick();
    check_val("x7_stored", id_ex.rs1_data, 32'hDEADBEEF);

    // flush wins over stall
    drive(I_LW, 32'h124);
    tick();
    drive(I_ADD322, 32'h128);
    flush_id = 1'b1;
    #1;
    check_val("flush_stall", {31'd0, stall}, 32'd0);
    tick();
    flush_id = 1'b0;
    check_val("flush_valid", {31'd0, id_ex.valid}, 32'd0);
    check_val("flush_reg_write", {31'd0, id_ex.reg_write}, 32'd0);

    // illegal encodings
    drive(I_ILL1, 32'h12C);
    tick();
    check_val("ill_flag", {31'd0, id_ex.illegal}, 32'd1);
    check_val("ill_valid", {31'd0, id_ex.valid}, 32'd1);
    check_val("ill_reg_write", {31'd0, id_ex.reg_write}, 32'd0);
    check_val("ill_mem_write", {31'd0, id_ex.mem_write}, 32'd0);
    drive(I_ILL2, 32'h130);
    tick();
    check_val("ill2_flag", {31'd0, id_ex.illegal}, 32'd1);
    check_val("ill2_reg_write", {31'd0, id_ex.reg_write}, 32'd0);
    drive(I_ILLOP, 32'h134);
    tick();
    check_val("illop_flag", {31'd0, id_ex.illegal}, 32'd1);
    check_val("illop_reg_write", {31'd0, id_ex.reg_write}, 32'd0);

    // branch, ECALL and store
    drive(I_BEQ, 32'h138);
    tick();
    check_val("beq_imm", id_ex.imm, 32'hFFFFFFF8);
    check_val("beq_branch", {31'd0, id_ex.branch}, 32'd1);
    check_val("beq_reg_write", {31'd0, id_ex.reg_write}, 32'd0);
    check_val("beq_illegal", {31'd0, id_ex.illegal}, 32'd0);
    drive(I_ECALL, 32'h13C);
    tick();
    check_val("ecall_valid", {31'd0, id_ex.valid}, 32'd1);
    check_val("ecall_illegal", {31'd0, id_ex.illegal}, 32'd0);
    check_val("ecall_reg_write", {31'd0, id_ex.reg_write}, 32'd0);
    drive(I_SW, 32'h140);
    tick();
    check_val("sw_imm", id_ex.imm, 32'hFFFFFFFC);
    check_val("sw_mem_write", {31'd0, id_ex.mem_write}, 32'd1);
    check_val("sw_reg_write", {31'd0, id_ex.reg_write}, 32'd0);

    // empty slot
    if_id.valid = 1'b0;
    tick();
    check_val("idle_valid", {31'd0, id_ex.valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
